// File: rtl/mcsr.sv
// rtl/mcsr.sv - RV32 machine-mode CSR file (mstatus/misa/mie/mtvec/mscratch/mepc/mcause/mtval/mip/id CSRs)
//
// Purpose: holds the machine-mode trap state of a single-hart RV32I core.
// It serves combinational CSR reads and takes CSR writes, trap entry and trap return
// updates at the next rising edge.
//
// Optional feature: define MCSR_COUNTER_EN to build the 64-bit mcycle/minstret
// counters (0xB00/0xB80, 0xB02/0xB82). Without it those addresses read 0, and
// writes to them are accepted silently.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   csr_rd, csr_wr, csr_addr        CSR access strobes and address
//   csr_wdata                       final write data (RW/RS/RC already applied)
//   csr_rdata, csr_ill              combinational read data, illegal-access flag
//   trap_enter, mret                trap entry / trap return strobes
//   i_mcause_*, i_mepc_value,
//   i_mtval_value, i_mstatus_*      values loaded on trap entry / return
//   instr_retire                    retire strobe for minstret
//   sw/timer/ext_irq_raw            raw interrupt lines (visible in mip)
//   o_mtvec_*, o_mstatus_*,
//   o_mepc_value                    register copies for the trap controller
//   software/timer/external_interrupt  pending and enabled interrupts
module mcsr #(
  parameter logic [31:0] MTVEC_RESET = 32'h0,
  parameter logic [31:0] MISA_VALUE  = 32'h40000100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        csr_rd,
  input  logic        csr_wr,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic        csr_ill,
  input  logic        trap_enter,
  input  logic        mret,
  input  logic [30:0] i_mcause_exception_code,
  input  logic        i_mcause_interrupt,
  input  logic [31:0] i_mepc_value,
  input  logic [31:0] i_mtval_value,
  input  logic        i_mstatus_mie,
  input  logic        i_mstatus_mpie,
  input  logic [1:0]  i_mstatus_mpp,
  input  logic        instr_retire,
  input  logic        sw_irq_raw,
  input  logic        timer_irq_raw,
  input  logic        ext_irq_raw,
  output logic [29:0] o_mtvec_base,
  output logic [1:0]  o_mtvec_mode,
  output logic        o_mstatus_mie,
  output logic        o_mstatus_mpie,
  output logic [31:0] o_mepc_value,
  output logic        software_interrupt,
  output logic        timer_interrupt,
  output logic        external_interrupt
);

  localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
  localparam logic [11:0] ADDR_MISA      = 12'h301;
  localparam logic [11:0] ADDR_MIE       = 12'h304;
  localparam logic [11:0] ADDR_MTVEC     = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
  localparam logic [11:0] ADDR_MEPC      = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
  localparam logic [11:0] ADDR_MTVAL     = 12'h343;
  localparam logic [11:0] ADDR_MIP       = 12'h344;
  localparam logic [11:0] ADDR_MVENDORID = 12'hF11;
  localparam logic [11:0] ADDR_MARCHID   = 12'hF12;
  localparam logic [11:0] ADDR_MIMPID    = 12'hF13;
  localparam logic [11:0] ADDR_MHARTID   = 12'hF14;
  localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
  localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;

  // Architectural state
  logic        mstatus_mie_q;
  logic        mstatus_mpie_q;
  logic        mie_msie_q;
  logic        mie_mtie_q;
  logic        mie_meie_q;
  logic [29:0] mtvec_base_q;
  logic [1:0]  mtvec_mode_q;
  logic [31:0] mscratch_q;
  logic [31:0] mepc_q;
  logic [31:0] mcause_q;
  logic [31:0] mtval_q;

  // Address decode results
  logic        addr_known;
  logic        addr_read_only;
  logic        wr_mstatus;
  logic        wr_mie;
  logic        wr_mtvec;
  logic        wr_mscratch;
  logic        wr_mepc;
  logic        wr_mcause;
  logic        wr_mtval;

  logic [31:0] mstatus_rd;
  logic [31:0] mie_rd;
  logic [31:0] mip_rd;

  // MPP is hard-wired to machine mode, so the trap-controller value is not stored
  logic [1:0]  unused_mpp;
  assign unused_mpp = i_mstatus_mpp;

  assign mstatus_rd = {19'b0, 2'b11, 3'b0, mstatus_mpie_q, 3'b0, mstatus_mie_q, 3'b0};
  assign mie_rd     = {20'b0, mie_meie_q, 3'b0, mie_mtie_q, 3'b0, mie_msie_q, 3'b0};
  assign mip_rd     = {20'b0, ext_irq_raw, 3'b0, timer_irq_raw, 3'b0, sw_irq_raw, 3'b0};

`ifdef MCSR_COUNTER_EN
  logic [63:0] mcycle_q;
  logic [63:0] mcycle_d;
  logic [63:0] minstret_q;
  logic [63:0] minstret_d;
`endif

  // Read mux and legality decode
  always_comb begin
    csr_rdata      = 32'h0;
    addr_known     = 1'b0;
    addr_read_only = 1'b0;
    case (csr_addr)
      ADDR_MSTATUS:  begin csr_rdata = mstatus_rd;   addr_known = 1'b1; end
      ADDR_MISA:     begin csr_rdata = MISA_VALUE;   addr_known = 1'b1; end
      ADDR_MIE:      begin csr_rdata = mie_rd;       addr_known = 1'b1; end
      ADDR_MTVEC:    begin csr_rdata = {mtvec_base_q, mtvec_mode_q}; addr_known = 1'b1; end
      ADDR_MSCRATCH: begin csr_rdata = mscratch_q;   addr_known = 1'b1; end
      ADDR_MEPC:     begin csr_rdata = mepc_q;       addr_known = 1'b1; end
      ADDR_MCAUSE:   begin csr_rdata = mcause_q;     addr_known = 1'b1; end
      ADDR_MTVAL:    begin csr_rdata = mtval_q;      addr_known = 1'b1; end
      ADDR_MIP: begin
        csr_rdata      = mip_rd;
        addr_known     = 1'b1;
        addr_read_only = 1'b1;
      end
      ADDR_MVENDORID, ADDR_MARCHID, ADDR_MIMPID, ADDR_MHARTID: begin
        addr_known     = 1'b1;
        addr_read_only = 1'b1;
      end
      // Counter addresses are always legal; they read 0 when the counters are absent
      ADDR_MCYCLE: begin
        addr_known = 1'b1;
`ifdef MCSR_COUNTER_EN
        csr_rdata  = mcycle_q[31:0];
`endif
      end
      ADDR_MCYCLEH: begin
        addr_known = 1'b1;
`ifdef MCSR_COUNTER_EN
        csr_rdata  = mcycle_q[63:32];
`endif
      end
      ADDR_MINSTRET: begin
        addr_known = 1'b1;
`ifdef MCSR_COUNTER_EN
        csr_rdata  = minstret_q[31:0];
`endif
      end
      ADDR_MINSTRETH: begin
        addr_known = 1'b1;
`ifdef MCSR_COUNTER_EN
        csr_rdata  = minstret_q[63:32];
`endif
      end
      default: ;
    endcase
  end

  // misa is read-only but its writes are deliberately not flagged
  assign csr_ill = ((csr_rd | csr_wr) & ~addr_known) | (csr_wr & addr_read_only);

  assign wr_mstatus  = csr_wr & (csr_addr == ADDR_MSTATUS);
  assign wr_mie      = csr_wr & (csr_addr == ADDR_MIE);
  assign wr_mtvec    = csr_wr & (csr_addr == ADDR_MTVEC);
  assign wr_mscratch = csr_wr & (csr_addr == ADDR_MSCRATCH);
  assign wr_mepc     = csr_wr & (csr_addr == ADDR_MEPC);
  assign wr_mcause   = csr_wr & (csr_addr == ADDR_MCAUSE);
  assign wr_mtval    = csr_wr & (csr_addr == ADDR_MTVAL);

  // State update: trap_enter beats mret beats CSR write on shared registers
  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_msie_q     <= 1'b0;
      mie_mtie_q     <= 1'b0;
      mie_meie_q     <= 1'b0;
      mtvec_base_q   <= MTVEC_RESET[31:2];
      mtvec_mode_q   <= 2'b00;
      mscratch_q     <= 32'h0;
      mepc_q         <= 32'h0;
      mcause_q       <= 32'h0;
      mtval_q        <= 32'h0;
    end else begin
      if (trap_enter) begin
        mstatus_mie_q  <= i_mstatus_mie;
        mstatus_mpie_q <= i_mstatus_mpie;
        mepc_q         <= {i_mepc_value[31:2], 2'b00};
        mcause_q       <= {i_mcause_interrupt, i_mcause_exception_code};
        mtval_q        <= i_mtval_value;
      end else begin
        if (mret) begin
          mstatus_mie_q  <= i_mstatus_mie;
          mstatus_mpie_q <= i_mstatus_mpie;
        end else if (wr_mstatus) begin
          mstatus_mie_q  <= csr_wdata[3];
          mstatus_mpie_q <= csr_wdata[7];
        end
        if (wr_mepc)   mepc_q   <= {csr_wdata[31:2], 2'b00};
        if (wr_mcause) mcause_q <= csr_wdata;
        if (wr_mtval)  mtval_q  <= csr_wdata;
      end

      if (wr_mie) begin
        mie_msie_q <= csr_wdata[3];
        mie_mtie_q <= csr_wdata[7];
        mie_meie_q <= csr_wdata[11];
      end
      // Modes 2 and 3 are reserved: keep the previous mode, still take the base
      if (wr_mtvec) begin
        mtvec_base_q <= csr_wdata[31:2];
        if (!csr_wdata[1]) mtvec_mode_q <= csr_wdata[1:0];
      end
      if (wr_mscratch) mscratch_q <= csr_wdata;
    end
  end

`ifdef MCSR_COUNTER_EN
  // A write to either half takes that half and suppresses the tick for the cycle
  always_comb begin
    mcycle_d   = mcycle_q + 64'd1;
    minstret_d = minstret_q + {63'd0, instr_retire};
    if (csr_wr) begin
      case (csr_addr)
        ADDR_MCYCLE:    mcycle_d   = {mcycle_q[63:32], csr_wdata};
        ADDR_MCYCLEH:   mcycle_d   = {csr_wdata, mcycle_q[31:0]};
        ADDR_MINSTRET:  minstret_d = {minstret_q[63:32], csr_wdata};
        ADDR_MINSTRETH: minstret_d = {csr_wdata, minstret_q[31:0]};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcycle_q   <= 64'd0;
      minstret_q <= 64'd0;
    end else begin
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end
`else
  logic unused_instr_retire;
  assign unused_instr_retire = instr_retire;
`endif

  // Gated by rst so nothing is signalled while the enables are being cleared
  assign software_interrupt = sw_irq_raw    & mie_msie_q & ~rst;
  assign timer_interrupt    = timer_irq_raw & mie_mtie_q & ~rst;
  assign external_interrupt = ext_irq_raw   & mie_meie_q & ~rst;

  assign o_mtvec_base   = mtvec_base_q;
  assign o_mtvec_mode   = mtvec_mode_q;
  assign o_mstatus_mie  = mstatus_mie_q;
  assign o_mstatus_mpie = mstatus_mpie_q;
  assign o_mepc_value   = mepc_q;

endmodule

// File: tb/tb_mcsr.sv
// tb/tb_mcsr.sv - table-driven self-checking bench for mcsr
module tb_mcsr;

  logic        clk = 1'b0;
  logic        rst;
  logic        csr_rd, csr_wr;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata, csr_rdata;
  logic        csr_ill;
  logic        trap_enter, mret;
  logic [30:0] i_mcause_exception_code;
  logic        i_mcause_interrupt;
  logic [31:0] i_mepc_value, i_mtval_value;
  logic        i_mstatus_mie, i_mstatus_mpie;
  logic [1:0]  i_mstatus_mpp;
  logic        instr_retire;
  logic        sw_irq_raw, timer_irq_raw, ext_irq_raw;
  logic [29:0] o_mtvec_base;
  logic [1:0]  o_mtvec_mode;
  logic        o_mstatus_mie, o_mstatus_mpie;
  logic [31:0] o_mepc_value;
  logic        software_interrupt, timer_interrupt, external_interrupt;

  mcsr #(.MTVEC_RESET(32'h0000_1003), .MISA_VALUE(32'h4000_0100)) dut (
    .clk(clk), .rst(rst), .csr_rd(csr_rd), .csr_wr(csr_wr), .csr_addr(csr_addr),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .csr_ill(csr_ill),
    .trap_enter(trap_enter), .mret(mret),
    .i_mcause_exception_code(i_mcause_exception_code), .i_mcause_interrupt(i_mcause_interrupt),
    .i_mepc_value(i_mepc_value), .i_mtval_value(i_mtval_value),
    .i_mstatus_mie(i_mstatus_mie), .i_mstatus_mpie(i_mstatus_mpie), .i_mstatus_mpp(i_mstatus_mpp),
    .instr_retire(instr_retire),
    .sw_irq_raw(sw_irq_raw), .timer_irq_raw(timer_irq_raw), .ext_irq_raw(ext_irq_raw),
    .o_mtvec_base(o_mtvec_base), .o_mtvec_mode(o_mtvec_mode),
    .o_mstatus_mie(o_mstatus_mie), .o_mstatus_mpie(o_mstatus_mpie), .o_mepc_value(o_mepc_value),
    .software_interrupt(software_interrupt), .timer_interrupt(timer_interrupt),
    .external_interrupt(external_interrupt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        wr_ill;
    logic [31:0] rdata;
    logic        rd_ill;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
    csr_wr = 1'b1; csr_addr = a; csr_wdata = d;
    tick();
    csr_wr = 1'b0;
  endtask

  task automatic csr_read(input logic [11:0] a, output logic [31:0] d, output logic ill);
    csr_rd = 1'b1; csr_addr = a;
    #1;
    d = csr_rdata; ill = csr_ill;
    csr_rd = 1'b0;
  endtask

  function automatic logic [31:0] irqs();
    return {29'b0, software_interrupt, timer_interrupt, external_interrupt};
  endfunction

  logic [31:0] rd;
  logic        ill;

  initial begin
    // addr, wdata, write-ill, read-back, read-ill
    vecs[0]  = '{12'h340, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0};
    vecs[1]  = '{12'h341, 32'h12345677, 1'b0, 32'h12345674, 1'b0};
    vecs[2]  = '{12'h342, 32'h80000007, 1'b0, 32'h80000007, 1'b0};
    vecs[3]  = '{12'h343, 32'hCAFEF00D, 1'b0, 32'hCAFEF00D, 1'b0};
    vecs[4]  = '{12'h300, 32'hFFFFFFFF, 1'b0, 32'h00001888, 1'b0};
    vecs[5]  = '{12'h300, 32'h00000000, 1'b0, 32'h00001800, 1'b0};
    vecs[6]  = '{12'h301, 32'h00000000, 1'b0, 32'h40000100, 1'b0};
    vecs[7]  = '{12'h304, 32'hFFFFFFFF, 1'b0, 32'h00000888, 1'b0};
    vecs[8]  = '{12'h305, 32'h00001001, 1'b0, 32'h00001001, 1'b0};
    vecs[9]  = '{12'h305, 32'h00002003, 1'b0, 32'h00002001, 1'b0};
    vecs[10] = '{12'h305, 32'h00004002, 1'b0, 32'h00004001, 1'b0};
    vecs[11] = '{12'h305, 32'h00000000, 1'b0, 32'h00000000, 1'b0};
    vecs[12] = '{12'hF11, 32'h00000005, 1'b1, 32'h00000000, 1'b0};
    vecs[13] = '{12'hF14, 32'h00000007, 1'b1, 32'h00000000, 1'b0};
    vecs[14] = '{12'h7C0, 32'h12345678, 1'b1, 32'h00000000, 1'b1};
    vecs[15] = '{12'h344, 32'hFFFFFFFF, 1'b1, 32'h00000000, 1'b0};

    rst = 1'b1; csr_rd = 1'b0; csr_wr = 1'b0; csr_addr = 12'h0; csr_wdata = 32'h0;
    trap_enter = 1'b0; mret = 1'b0; i_mcause_exception_code = 31'h0; i_mcause_interrupt = 1'b0;
    i_mepc_value = 32'h0; i_mtval_value = 32'h0; i_mstatus_mie = 1'b0; i_mstatus_mpie = 1'b0;
    i_mstatus_mpp = 2'b11; instr_retire = 1'b0;
    sw_irq_raw = 1'b0; timer_irq_raw = 1'b0; ext_irq_raw = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Reset state; MTVEC_RESET low bits must be dropped
    sw_irq_raw = 1'b1; timer_irq_raw = 1'b1; ext_irq_raw = 1'b1;
    csr_read(12'h300, rd, ill); chk("rst mstatus", rd, 32'h1800);
    csr_read(12'h305, rd, ill); chk("rst mtvec", rd, 32'h1000);
    chk("rst mtvec_mode", {30'b0, o_mtvec_mode}, 32'h0);
    csr_read(12'h341, rd, ill); chk("rst mepc", rd, 32'h0);
    chk("rst irqs", irqs(), 32'h0);
    sw_irq_raw = 1'b0; timer_irq_raw = 1'b0; ext_irq_raw = 1'b0;

    for (int i = 0; i < NV; i++) begin
      csr_wr = 1'b1; csr_addr = vecs[i].addr; csr_wdata = vecs[i].wdata;
      #1;
      chk($sformatf("v%0d wr_ill", i), {31'b0, csr_ill}, {31'b0, vecs[i].wr_ill});
      tick();
      csr_wr = 1'b0;
      csr_read(vecs[i].addr, rd, ill);
      chk($sformatf("v%0d rdata", i), rd, vecs[i].rdata);
      chk($sformatf("v%0d rd_ill", i), {31'b0, ill}, {31'b0, vecs[i].rd_ill});
    end
    chk("mepc out", o_mepc_value, 32'h12345674);

    // Same-cycle read sees the old value
    csr_wr = 1'b1; csr_rd = 1'b1; csr_addr = 12'h340; csr_wdata = 32'h11111111;
    #1; chk("old value on write", csr_rdata, 32'hDEADBEEF);
    tick(); csr_wr = 1'b0; csr_rd = 1'b0;
    csr_read(12'h340, rd, ill); chk("new value after write", rd, 32'h11111111);

    // mtvec WARL on the outputs
    csr_write(12'h305, 32'h00001001);
    chk("mtvec base 1", {2'b0, o_mtvec_base}, 32'h400);
    chk("mtvec mode 1", {30'b0, o_mtvec_mode}, 32'h1);
    csr_write(12'h305, 32'h00002003);
    chk("mtvec base 2", {2'b0, o_mtvec_base}, 32'h800);
    chk("mtvec mode kept", {30'b0, o_mtvec_mode}, 32'h1);

    // Trap entry beats a simultaneous mepc write
    csr_write(12'h300, 32'h00000008);
    trap_enter = 1'b1; i_mepc_value = 32'h103; i_mcause_exception_code = 31'd11;
    i_mcause_interrupt = 1'b1; i_mstatus_mie = 1'b0; i_mstatus_mpie = 1'b1;
    i_mtval_value = 32'h000055AA;
    csr_write(12'h341, 32'hAAAA0000);
    trap_enter = 1'b0;
    csr_read(12'h341, rd, ill); chk("trap mepc", rd, 32'h100);
    chk("trap mepc out", o_mepc_value, 32'h100);
    csr_read(12'h342, rd, ill); chk("trap mcause", rd, 32'h8000000B);
    csr_read(12'h343, rd, ill); chk("trap mtval", rd, 32'h55AA);
    csr_read(12'h300, rd, ill); chk("trap mstatus", rd, 32'h1880);
    chk("trap mie/mpie out", {30'b0, o_mstatus_mpie, o_mstatus_mie}, 32'h2);

    // Trap entry leaves a non-conflicting mscratch write alone
    trap_enter = 1'b1; i_mepc_value = 32'h200; i_mcause_exception_code = 31'd3;
    i_mcause_interrupt = 1'b0; i_mstatus_mie = 1'b1; i_mstatus_mpie = 1'b0; i_mtval_value = 32'h0;
    csr_write(12'h340, 32'h22222222);
    trap_enter = 1'b0;
    csr_read(12'h340, rd, ill); chk("trap mscratch write", rd, 32'h22222222);
    csr_read(12'h342, rd, ill); chk("trap2 mcause", rd, 32'h3);
    csr_read(12'h300, rd, ill); chk("trap2 mstatus", rd, 32'h1808);

    // mret beats mstatus write; mepc write still lands, mcause untouched
    mret = 1'b1; i_mstatus_mie = 1'b0; i_mstatus_mpie = 1'b1;
    csr_write(12'h300, 32'h00000088);
    csr_read(12'h300, rd, ill); chk("mret over write", rd, 32'h1880);
    i_mstatus_mie = 1'b1; i_mstatus_mpie = 1'b1;
    csr_write(12'h341, 32'h00000302);
    mret = 1'b0;
    csr_read(12'h341, rd, ill); chk("mret mepc write", rd, 32'h300);
    csr_read(12'h342, rd, ill); chk("mret mcause kept", rd, 32'h3);
    csr_read(12'h300, rd, ill); chk("mret mstatus", rd, 32'h1888);

    // Interrupt enables
    csr_write(12'h304, 32'h00000080);
    timer_irq_raw = 1'b1; #1;
    chk("timer only", irqs(), 32'h2);
    csr_read(12'h344, rd, ill); chk("mip timer", rd, 32'h80);
    sw_irq_raw = 1'b1; ext_irq_raw = 1'b1; #1;
    chk("sw/ext disabled", irqs(), 32'h2);
    csr_read(12'h344, rd, ill); chk("mip all", rd, 32'h888);
    csr_write(12'h304, 32'h00000000);
    chk("mie zero", irqs(), 32'h0);
    csr_write(12'h304, 32'h00000808);
    chk("sw+ext", irqs(), 32'h5);
    timer_irq_raw = 1'b0; sw_irq_raw = 1'b0; ext_irq_raw = 1'b0; #1;
    chk("raw low", irqs(), 32'h0);

`ifdef MCSR_COUNTER_EN
    csr_write(12'hB00, 32'hFFFFFFFF);
    tick();
    csr_read(12'hB80, rd, ill); chk("mcycleh carry", rd, 32'h1);
    csr_read(12'hB00, rd, ill); chk("mcycle wrap", rd, 32'h0);
    instr_retire = 1'b1;
    csr_write(12'hB02, 32'h5);
    tick(); tick(); tick();
    instr_retire = 1'b0;
    csr_read(12'hB02, rd, ill); chk("minstret count", rd, 32'h8);
    csr_read(12'hB82, rd, ill); chk("minstreth", rd, 32'h0);
`else
    csr_write(12'hB00, 32'hFFFFFFFF);
    csr_read(12'hB00, rd, ill); chk("mcycle absent", rd, 32'h0);
    chk("mcycle ill", {31'b0, ill}, 32'h0);
    csr_read(12'hB82, rd, ill); chk("minstreth absent", rd, 32'h0);
`endif

    // Reset overrides a trap and a CSR write in the same cycle
    csr_write(12'h304, 32'h00000888);
    sw_irq_raw = 1'b1; timer_irq_raw = 1'b1; ext_irq_raw = 1'b1; #1;
    chk("pre-reset irqs", irqs(), 32'h7);
    rst = 1'b1; trap_enter = 1'b1; i_mepc_value = 32'h400; i_mstatus_mie = 1'b1;
    i_mstatus_mpie = 1'b1; i_mcause_exception_code = 31'd7;
    csr_wr = 1'b1; csr_addr = 12'h340; csr_wdata = 32'h33333333;
    #1; chk("irqs during reset", irqs(), 32'h0);
    tick();
    rst = 1'b0; trap_enter = 1'b0; csr_wr = 1'b0;
    csr_read(12'h341, rd, ill); chk("reset mepc", rd, 32'h0);
    csr_read(12'h300, rd, ill); chk("reset mstatus", rd, 32'h1800);
    csr_read(12'h340, rd, ill); chk("reset mscratch", rd, 32'h0);
    csr_read(12'h342, rd, ill); chk("reset mcause", rd, 32'h0);
    chk("irqs after reset", irqs(), 32'h0);
    chk("reset mtvec base", {2'b0, o_mtvec_base}, 32'h400);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
